somador_arbiter: RTL and testbench
==================================

// Module: somador_arbiter
// PURPOSE
//  Shares one registered W-bit adder among NUM_REQ requesters using round-robin arbitration.
//  Each requester presents operands with a valid/ready handshake.
//  The granted pair is summed into a single output register, tagged with the requester index.
//  Sits between the operand producers and the downstream sum consumer, which can apply back-pressure.
// PARAMETERS
//  WIDTH    44  operand/sum width in bits
//  NUM_REQ  4   number of requesters (2..16)
//  ID_W     2   requester-id width, = clog2(NUM_REQ); set via package function
// PORTS
//  clock      in   1              rising-edge clock
//  reset_n    in   1              asynchronous active-low reset
//  req_valid  in   NUM_REQ        per-requester operand valid
//  req_x      in   NUM_REQ*WIDTH  operand x, requester i at [i*WIDTH +: WIDTH]
//  req_y      in   NUM_REQ*WIDTH  operand y, same packing
//  req_ready  out  NUM_REQ        one-hot grant; handshake when req_valid[i] & req_ready[i]
//  res_valid  out  1              result register holds a sum
//  res_ready  in   1              consumer accepts result
//  res_sum    out  WIDTH          (x+y) mod 2^WIDTH
//  res_id     out  ID_W           index of the requester that produced res_sum
// BEHAVIOUR
//  - Reset (async, reset_n=0): res_valid=0, res_sum=0, res_id=0, rr_ptr=0. Any in-flight result is dropped.
//  - Reset state of req_ready: combinational. All zero while res_valid=1 and res_ready=0.
//  - slot_free = !res_valid | res_ready. A grant is issued only when slot_free=1.
//  - Grant selection: scan indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//  - The first index with req_valid set gets req_ready=1. At most one bit of req_ready is high.
//  - req_ready is combinational from req_valid, rr_ptr, res_valid and res_ready.
//  - It must not depend on req_x or req_y.
//  - On a handshake for index g at edge t:
//    - res_sum <= x_g + y_g
//    - res_id <= g
//    - res_valid <= 1
//    - rr_ptr <= (g+1) mod NUM_REQ
//  - Latency: exactly 1 cycle from handshake to res_valid.
//  - Consume without new grant: res_valid & res_ready with no handshake gives res_valid <= 0.
//  - Consume and grant in the same cycle: res_valid stays 1 and the register reloads (full throughput, 1 sum/cycle).
//  - Stall: while res_valid & !res_ready, res_sum and res_id are held stable and rr_ptr is unchanged.
//  - Idle: no req_valid means rr_ptr is unchanged.
//  - Requesters hold req_valid and operands stable until their handshake; the block never drops an asserted request.
//  - Fairness: with all requesters continuously valid and no stall, grants rotate 0,1,2,...,NUM_REQ-1,0.
//  - Arithmetic: unsigned, wrap-around modulo 2^WIDTH (all-ones + 1 = 0).
// CONFIGURATION
//  - ADDER_CARRY_OUT_EN defined:
//    - Extra port res_carry (out, 1) = bit WIDTH of the (WIDTH+1)-bit sum.
//    - res_carry is registered alongside res_sum; reset value 0.
//  - ADDER_CARRY_OUT_EN undefined: no res_carry port; the carry is discarded.
// STRUCTURE
//  - Package somador_pkg:
//    - DEFAULT_WIDTH=44
//    - DEFAULT_NUM_REQ=4
//    - clog2 function used to derive ID_W
//  - Sub-module rr_arbiter (NUM_REQ):
//    - inputs: req, ptr, enable
//    - outputs: one-hot grant, encoded grant index
//  - Top level: slot_free logic, operand mux, adder, output/pointer registers.
// TESTING
//  1. Single request: req0 x=4 y=8 -> req_ready[0]=1 that cycle; next cycle res_valid=1, res_sum=12, res_id=0.
//  2. Contention: req1 (11+40) and req2 (4+5) both valid, rr_ptr=0.
//     -> grant 1 first (res_sum=51, id=1); next cycle grant 2 (res_sum=9, id=2); rr_ptr ends at 3.
//  3. Back-pressure: res_ready=0 for 5 cycles with req3 (38+62) pending
//     -> req_ready=0, result held stable; after res_ready=1, the 100/id=3 result appears 1 cycle later.
//  4. Wrap: x=2^44-1, y=1 -> res_sum=0. With ADDER_CARRY_OUT_EN, res_carry=1; without it, no carry port.
//  5. Reset mid-operation: reset_n low while res_valid=1
//     -> res_valid=0 immediately (async), rr_ptr=0; first grant after release goes to the lowest valid index.
//  6. Saturation: all 4 valid for 8 cycles with res_ready=1 -> ids 0,1,2,3,0,1,2,3 back-to-back, no bubbles.

Source files
------------

// File: rtl/somador_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// somador_pkg
// Shared constants and helpers for the round-robin shared-adder block.
//   DEFAULT_WIDTH   : default operand/sum width
//   DEFAULT_NUM_REQ : default number of requesters
//   clog2()         : ceiling log2, used to size the requester-id field
// -----------------------------------------------------------------------------
package somador_pkg;

    localparam int DEFAULT_WIDTH   = 44;
    localparam int DEFAULT_NUM_REQ = 4;

    // Smallest n with 2**n >= value (value >= 2 in every legal configuration).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            result = ((32'd1 << i) < 32'(value)) ? (i + 1) : result;
        end
        return result;
    endfunction

endpackage

// File: rtl/somador_arbiter_if.sv
// -----------------------------------------------------------------------------
// somador_arbiter_if
// Handshake bundle between the operand producers / sum consumer and the
// shared adder.
//   req_valid [NUM_REQ]        : per-requester operand valid
//   req_x/req_y [NUM_REQ*WIDTH]: operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready [NUM_REQ]        : one-hot grant
//   res_valid/res_ready        : result handshake
//   res_sum [WIDTH], res_id [ID_W]
//   res_carry                  : only when ADDER_CARRY_OUT_EN is defined
// Modports: master = producers/consumer side, slave = adder block.
// -----------------------------------------------------------------------------
interface somador_arbiter_if
    import somador_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W    = clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_x;
    logic [NUM_REQ*WIDTH-1:0] req_y;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     res_valid;
    logic                     res_ready;
    logic [WIDTH-1:0]         res_sum;
    logic [ID_W-1:0]          res_id;
`ifdef ADDER_CARRY_OUT_EN
    logic                     res_carry;

    modport master (
        output req_valid, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_sum, res_id, res_carry
    );

    modport slave (
        input  req_valid, req_x, req_y, res_ready,
        output req_ready, res_valid, res_sum, res_id, res_carry
    );
`else
    modport master (
        output req_valid, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_sum, res_id
    );

    modport slave (
        input  req_valid, req_x, req_y, res_ready,
        output req_ready, res_valid, res_sum, res_id
    );
`endif

endinterface

// File: rtl/somador_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Starting at i_ptr and walking
// upward modulo NUM_REQ, the first asserted request wins.
//   i_req        [NUM_REQ] : request vector
//   i_ptr        [ID_W]    : highest-priority index this cycle
//   i_enable               : when low no grant is issued
//   o_grant      [NUM_REQ] : one-hot grant (all zero if none)
//   o_grant_idx  [ID_W]    : encoded index of the grant (0 if none)
//   o_grant_valid          : a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter
    import somador_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_grant_valid
);

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_found;
    logic [ID_W-1:0]    w_idx;
    logic               w_hit;

    // Rotating priority scan; w_found blocks every candidate after the first hit.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        w_hit       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx          = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            w_hit          = i_enable & ~w_found & i_req[w_idx];
            w_grant[w_idx] = w_grant[w_idx] | w_hit;
            w_grant_idx    = w_hit ? w_idx : w_grant_idx;
            w_found        = w_found | w_hit;
        end
    end

    assign o_grant       = w_grant;
    assign o_grant_idx   = w_grant_idx;
    assign o_grant_valid = w_found;

endmodule

// File: rtl/somador_arbiter.sv
// -----------------------------------------------------------------------------
// somador_arbiter
// One registered WIDTH-bit adder shared by NUM_REQ requesters under
// round-robin arbitration. The winning pair is summed into a single output
// register tagged with the requester index; a result may be consumed and a new
// one loaded in the same cycle, giving one sum per clock under saturation.
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : somador_arbiter_if.slave (req_valid/req_x/req_y/req_ready,
//              res_valid/res_ready/res_sum/res_id[/res_carry])
// Optional feature macro: ADDER_CARRY_OUT_EN adds the registered res_carry
// output (bit WIDTH of the full sum); otherwise the carry is discarded.
// req_ready is combinational and depends only on req_valid, the rotation
// pointer and the result-slot state, never on the operands.
// -----------------------------------------------------------------------------
module somador_arbiter
    import somador_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic              clock,
    input  logic              reset_n,
    somador_arbiter_if.slave  bus
);

    logic                 r_res_valid;
    logic [WIDTH-1:0]     r_res_sum;
    logic [ID_W-1:0]      r_res_id;
    logic [ID_W-1:0]      r_rr_ptr;

    logic                 w_slot_free;
    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_grant_idx;
    logic                 w_grant_valid;
    logic [WIDTH-1:0]     w_op_x;
    logic [WIDTH-1:0]     w_op_y;
    logic [WIDTH-1:0]     w_sum;
    logic [ID_W-1:0]      w_ptr_next;

    // The result register can take a new sum if it is empty or being drained now.
    assign w_slot_free = ~r_res_valid | bus.res_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req         (bus.req_valid),
        .i_ptr         (r_rr_ptr),
        .i_enable      (w_slot_free),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    assign bus.req_ready = w_grant;

    // AND-OR operand mux keyed by the one-hot grant.
    always_comb begin
        w_op_x = '0;
        w_op_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_op_x = w_op_x | (bus.req_x[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
            w_op_y = w_op_y | (bus.req_y[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
        end
    end

`ifdef ADDER_CARRY_OUT_EN
    logic [WIDTH:0] w_sum_full;
    logic           r_res_carry;

    assign w_sum_full = {1'b0, w_op_x} + {1'b0, w_op_y};
    assign w_sum      = w_sum_full[WIDTH-1:0];

    // Carry register loads together with the sum and holds otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_res_carry <= 1'b0;
        end else if (w_grant_valid) begin
            r_res_carry <= w_sum_full[WIDTH];
        end else begin
            r_res_carry <= r_res_carry;
        end
    end

    assign bus.res_carry = r_res_carry;
`else
    assign w_sum = w_op_x + w_op_y;
`endif

    // Pointer moves to the slot just after the winner, wrapping at NUM_REQ.
    assign w_ptr_next = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : (w_grant_idx + ID_W'(1));

    // Result register and rotation pointer; a grant reloads even while draining.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_grant_valid) begin
            r_res_valid <= 1'b1;
            r_res_sum   <= w_sum;
            r_res_id    <= w_grant_idx;
            r_rr_ptr    <= w_ptr_next;
        end else if (bus.res_ready) begin
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= r_res_valid;
        end
    end

    assign bus.res_valid = r_res_valid;
    assign bus.res_sum   = r_res_sum;
    assign bus.res_id    = r_res_id;

endmodule

// File: tb/tb_somador_arbiter.sv
// -----------------------------------------------------------------------------
// tb_somador_arbiter
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level model of the shared adder (slot occupancy, rotation
// pointer, requester pending table).
// -----------------------------------------------------------------------------
module tb_somador_arbiter;
    import somador_pkg::*;

    localparam int W   = 44;
    localparam int N   = 4;
    localparam int IDW = clog2(N);

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    int checks = 0;
    int errors = 0;

    // requester-side state: pending flag and held operands
    logic         pend [N];
    logic [W-1:0] ox   [N];
    logic [W-1:0] oy   [N];
    logic         rdy;

    // reference model of the result slot
    logic         m_valid;
    logic [W-1:0] m_sum;
    logic         m_carry;
    int           m_id;
    int           m_ptr;

    somador_arbiter_if #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW)) bus ();

    somador_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]       = pend[i];
            bus.req_x[i*W +: W]    = ox[i];
            bus.req_y[i*W +: W]    = oy[i];
        end
        bus.res_ready = rdy;
    endtask

    task automatic request(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        pend[i] = 1'b1;
        ox[i]   = x;
        oy[i]   = y;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum   = '0;
        m_carry = 1'b0;
        m_id    = 0;
        m_ptr   = 0;
    endtask

    // Winner under round-robin from m_ptr, or -1 if the slot is blocked / nobody asks.
    function automatic int model_grant();
        if (m_valid && !rdy) return -1;
        for (int k = 0; k < N; k++) begin
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        check_eq("res_valid", 64'(bus.res_valid), 64'(m_valid));
        check_eq("res_sum",   64'(bus.res_sum),   64'(m_sum));
        check_eq("res_id",    64'(bus.res_id),    64'(m_id));
`ifdef ADDER_CARRY_OUT_EN
        check_eq("res_carry", 64'(bus.res_carry), 64'(m_carry));
`endif
    endtask

    // One clock: check the combinational grant, take the edge, advance the model, check results.
    task automatic cycle();
        logic [N-1:0] eg;
        logic [W:0]   s;
        int           g;
        drive();
        #1;
        g  = model_grant();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        check_eq("req_ready", 64'(bus.req_ready), 64'(eg));
        @(posedge clock);
        #1;
        if (g >= 0) begin
            s       = {1'b0, ox[g]} + {1'b0, oy[g]};
            m_valid = 1'b1;
            m_sum   = s[W-1:0];
            m_carry = s[W];
            m_id    = g;
            m_ptr   = (g + 1) % N;
            pend[g] = 1'b0;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        check_outputs();
    endtask

    // Asynchronous reset pulse landing mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            ox[i]   = '0;
            oy[i]   = '0;
        end
        rdy = 1'b1;
        drive();
        model_reset();
        #1 reset_n = 1'b0;
        #2;
        check_outputs();
        @(posedge clock);
        #1 reset_n = 1'b1;

        // 1: single request
        request(0, 44'd4, 44'd8);
        cycle();
        check_eq("t1_sum", 64'(bus.res_sum), 64'd12);
        check_eq("t1_id",  64'(bus.res_id),  64'd0);

        // 2: contention from pointer 0
        do_reset();
        request(1, 44'd11, 44'd40);
        request(2, 44'd4, 44'd5);
        cycle();
        check_eq("t2_sum_a", 64'(bus.res_sum), 64'd51);
        check_eq("t2_id_a",  64'(bus.res_id),  64'd1);
        cycle();
        check_eq("t2_sum_b", 64'(bus.res_sum), 64'd9);
        check_eq("t2_id_b",  64'(bus.res_id),  64'd2);

        // 3: back-pressure; pointer now 3 so req3 beats req0
        rdy = 1'b0;
        request(3, 44'd38, 44'd62);
        request(0, 44'd1, 44'd2);
        for (int c = 0; c < 5; c++) begin
            cycle();
            check_eq("t3_hold_sum", 64'(bus.res_sum), 64'd9);
            check_eq("t3_hold_id",  64'(bus.res_id),  64'd2);
        end
        rdy = 1'b1;
        cycle();
        check_eq("t3_sum", 64'(bus.res_sum), 64'd100);
        check_eq("t3_id",  64'(bus.res_id),  64'd3);
        cycle();
        check_eq("t3_next_id", 64'(bus.res_id), 64'd0);

        // 4: wrap-around
        request(1, '1, 44'd1);
        cycle();
        check_eq("t4_sum", 64'(bus.res_sum), 64'd0);
`ifdef ADDER_CARRY_OUT_EN
        check_eq("t4_carry", 64'(bus.res_carry), 64'd1);
`endif

        // 5: reset while a result is held and requests wait
        rdy = 1'b0;
        request(3, 44'd7, 44'd7);
        request(2, 44'd3, 44'd3);
        cycle();
        do_reset();
        rdy = 1'b1;
        cycle();
        check_eq("t5_id", 64'(bus.res_id), 64'd2);
        cycle();
        check_eq("t5_id2", 64'(bus.res_id), 64'd3);

        // 6: saturation from a fresh pointer
        do_reset();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) request(i, W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}));
            end
            cycle();
            check_eq("t6_id",    64'(bus.res_id),    64'(c % N));
            check_eq("t6_valid", 64'(bus.res_valid), 64'd1);
        end

        // randomized traffic with random back-pressure and occasional extreme operands
        for (int c = 0; c < 600; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    if ($urandom_range(0, 7) == 0)
                        request(i, '1, W'($urandom_range(0, 3)));
                    else
                        request(i, W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}));
                end
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
